// File: rtl/ex_muldiv_pkg.sv
// Shared widths, RV32M func3 encodings and FSM states for the execute-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011,
        F_DIV    = 3'b100,
        F_DIVU   = 3'b101,
        F_REM    = 3'b110,
        F_REMU   = 3'b111
    } md_func_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Two's-complement magnitude when the operand is treated as negative.
    function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract if it fits.
module muldiv_div_step
    import ex_muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] dividend_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder stays below the divisor, so a borrow is the only "does not fit" case.
    always_comb begin
        shifted       = {rem, dividend[XLEN-1]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = ~diff[XLEN];
        rem_next      = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dividend_next = {dividend[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage; stalls the pipeline while computing.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            md_start,
    input  logic [2:0]      md_func3,
    input  logic [XLEN-1:0] md_op_a,
    input  logic [XLEN-1:0] md_op_b,
    input  logic            md_flush,
    output logic            md_busy,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    md_state_e         state, state_nxt;
    md_func_e          func, in_func;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_step;
    logic [XLEN-1:0]   opnd, result;
    logic              sign_a, sign_b;

    logic              accept, is_div, in_sign_a, in_sign_b;
    logic              div_zero, div_ovf, fast, last;
    logic [XLEN-1:0]   in_mag_a, in_mag_b, fast_result, calc_result;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem, div_dvd;
    logic              div_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd;

    // Request decode: operand signs, magnitudes and the special cases that skip CALC.
    always_comb begin
        in_func   = md_func_e'(md_func3);
        is_div    = md_func3[2];
        accept    = (state == MD_IDLE) & md_start & ~md_flush;
        in_sign_a = md_op_a[XLEN-1] & ((in_func == F_MULH) | (in_func == F_MULHSU) |
                                       (in_func == F_DIV)  | (in_func == F_REM));
        in_sign_b = md_op_b[XLEN-1] & ((in_func == F_MULH) | (in_func == F_DIV) |
                                       (in_func == F_REM));
        in_mag_a  = mag_of(md_op_a, in_sign_a);
        in_mag_b  = mag_of(md_op_b, in_sign_b);
        div_zero  = is_div & (md_op_b == '0);
        div_ovf   = ((in_func == F_DIV) | (in_func == F_REM)) &
                    (md_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (md_op_b == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN+1:0] fm_prod;

    always_comb begin
        fm_a    = {in_sign_a, md_op_a};
        fm_b    = {in_sign_b, md_op_b};
        fm_prod = (2*XLEN+2)'(fm_a) * (2*XLEN+2)'(fm_b);
        fast    = div_zero | div_ovf | ~is_div;
        if (div_zero)
            fast_result = md_func3[1] ? md_op_a : '1;
        else if (div_ovf)
            fast_result = md_func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (in_func == F_MUL)
            fast_result = fm_prod[XLEN-1:0];
        else
            fast_result = fm_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        fast = div_zero | div_ovf;
        if (div_zero)
            fast_result = md_func3[1] ? md_op_a : '1;
        else if (div_ovf)
            fast_result = md_func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else
            fast_result = '0;
    end
`endif

    muldiv_div_step u_div_step (
        .rem           (acc[2*XLEN-1:XLEN]),
        .dividend      (acc[XLEN-1:0]),
        .divisor       (opnd),
        .rem_next      (div_rem),
        .dividend_next (div_dvd),
        .q_bit         (div_q)
    );

    // One iteration per CALC cycle plus sign fix-up of the post-step accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_step = func[2] ? {div_rem, div_dvd | XLEN'(div_q)}
                           : {mul_sum, acc[XLEN-1:1]};
        last     = (cnt == CNT_W'(XLEN-1));
        prod     = (sign_a ^ sign_b) ? (2*XLEN)'(~acc_step + (2*XLEN)'(1)) : acc_step;
        quo      = mag_of(acc_step[XLEN-1:0], sign_a ^ sign_b);
        rmd      = mag_of(acc_step[2*XLEN-1:XLEN], sign_a);
        case (func)
            F_MUL:                     calc_result = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: calc_result = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             calc_result = quo;
            default:                   calc_result = rmd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MD_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_CALC;
            MD_CALC: begin
                if (md_flush)  state_nxt = MD_IDLE;
                else if (last) state_nxt = MD_DONE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func   <= F_MUL;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            result <= '0;
        end else if (accept) begin
            func   <= in_func;
            cnt    <= '0;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            opnd   <= is_div ? in_mag_b : in_mag_a;
            acc    <= {{XLEN{1'b0}}, (is_div ? in_mag_a : in_mag_b)};
            if (fast)
                result <= fast_result;
        end else if ((state == MD_CALC) && !md_flush) begin
            acc <= acc_step;
            if (last)
                result <= calc_result;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign md_busy   = (state != MD_IDLE);
    assign md_stall  = accept | (state == MD_CALC);
    assign md_done   = (state == MD_DONE) & ~md_flush;
    assign md_result = result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, latency, stall, flush and reset checks.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_func3;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        md_flush;
    logic        md_busy;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
    localparam int MS = 0;
`else
    localparam int ML = 33;
    localparam int MS = 32;
`endif

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stalls;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_func3  (md_func3),
        .md_op_a   (md_op_a),
        .md_op_b   (md_op_b),
        .md_flush  (md_flush),
        .md_busy   (md_busy),
        .md_stall  (md_stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every md_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: result %08h at cycle %0d", md_result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", md_result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input int lat);
        @(negedge clk);
        md_start = 1'b1;
        md_func3 = f;
        md_op_a  = a;
        md_op_b  = b;
        sb.push_back('{res: res, cyc: cyc + lat});
        #1;
        chk("stall_at_accept", 32'(md_stall), 32'd1);
        @(posedge clk);
        #1 md_start = 1'b0;
    endtask

    task automatic wait_idle(input int exp_stalls);
        int n;
        int st;
        n  = 0;
        st = 0;
        while (n < 60) begin
            @(negedge clk);
            if (!md_busy) break;
            if (md_stall) st++;
            n++;
        end
        chk("idle_reached", 32'(md_busy), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        if (exp_stalls >= 0) chk("stall_cycles", 32'(st), 32'(exp_stalls));
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        int t0;
        rst      = 1'b1;
        md_start = 1'b0;
        md_func3 = 3'b000;
        md_op_a  = '0;
        md_op_b  = '0;
        md_flush = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_result", md_result, 32'd0);
        rst = 1'b0;

        vecs = '{
            '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML, MS},
            '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML, MS},
            '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, ML, MS},
            '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, ML, MS},
            '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 32},
            '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 32},
            '{3'b101, 32'd100,       32'd7,         32'd14,        33, 32},
            '{3'b111, 32'd100,       32'd7,         32'd2,         33, 32},
            '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0},
            '{3'b111, 32'd5,         32'd0,         32'd5,         1,  0},
            '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0},
            '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  0},
            '{3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  0},
            '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  0}
        };
        foreach (vecs[i]) begin
            start_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            wait_idle(vecs[i].stalls);
        end

        // Flush at T+10 of a DIV: no done, result keeps 0xFFFFFFF9, restart at T+12 finishes at T+45.
        @(negedge clk);
        t0 = cyc + 1;
        start_op(3'b100, 32'd100, 32'd7, 32'd0, 0);
        void'(sb.pop_back());
        wait_until(t0 + 10);
        md_flush = 1'b1;
        @(posedge clk);
        #1 md_flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", 32'(md_busy), 32'd0);
        chk("flush_result_held", md_result, 32'hFFFF_FFF9);
        chk("flush_cycle", 32'(cyc), 32'(t0 + 11));
        start_op(3'b101, 32'd100, 32'd7, 32'd14, 33);
        chk("restart_cycle", 32'(cyc - 1), 32'(t0 + 12));
        wait_idle(32);

        // A second start during CALC is ignored; exactly one done with the first op's result.
        @(negedge clk);
        t0 = cyc + 1;
        start_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        wait_until(t0 + 5);
        md_start = 1'b1;
        md_func3 = 3'b011;
        md_op_a  = 32'h1234_5678;
        md_op_b  = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 md_start = 1'b0;
        wait_idle(-1);
        repeat (3) @(negedge clk);

        // Reset at T+20 of a DIVU clears everything at once; the next op is still correct.
        start_op(3'b101, 32'd1000, 32'd9, 32'd0, 0);
        t0 = cyc - 1;
        wait_until(t0 + 20);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_busy", 32'(md_busy), 32'd0);
        chk("midrst_stall", 32'(md_stall), 32'd0);
        chk("midrst_done", 32'(md_done), 32'd0);
        chk("midrst_result", md_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_op(3'b111, 32'd1000, 32'd9, 32'd1, 33);
        wait_idle(32);
        chk("result_held_after_done", md_result, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
